npc_ras: RTL and testbench
==========================

Name: npc_ras

Overview:
- Parametrised next-generation fetch-address unit for the five-stage MIPS pipeline.
- Owns the F-stage PC register and computes the next PC from D-stage control (sequential, branch, jump, register jump).
- Adds stall hold, exception/eret redirection, and a circular return-address stack (RAS).
- The RAS checks each `jr $ra` against the predicted target and counts mismatches for profiling.

Parameters:
- WIDTH, 32, address width; must be >= 32 so that J-type concatenation keeps pc_d[WIDTH-1:28].
- RAS_DEPTH, 8, RAS entries; power of two, >= 2.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry.
- CNT_W, 16, width of the mismatch counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  F/D stall; hold the PC.
- npcop  in  3  D-stage op: 0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5 JALR, 6 RET; 7 is treated as SEQ.
- cmp_true  in  1  branch condition, resolved in D.
- pc_d  in  WIDTH  PC of the instruction in D.
- imm16  in  16  branch offset.
- imm26  in  26  jump index.
- reg_target  in  WIDTH  forwarded rs value for JR/JALR/RET.
- exc_req  in  1  exception redirect request.
- eret  in  1  return from exception.
- epc  in  WIDTH  return address used by eret.
- pc  out  WIDTH  current F-stage PC (registered).
- pc_plus4  out  WIDTH  pc+4, combinational.
- pc_misaligned  out  1  pc[1:0]!=0, combinational.
- ras_miss  out  1  one-cycle registered pulse on RET misprediction.
- ras_miss_cnt  out  CNT_W  saturating count of RET mispredictions.
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset (synchronous, dominates everything):
  - pc=RESET_PC, RAS pointer=0, ras_count=0, ras_miss=0, ras_miss_cnt=0.
  - RAS entry contents are don't-care.
- Next-PC priority, applied each rising edge: exc_req > eret > stall > npcop.
  - exc_req: pc<=EXC_VECTOR.
  - eret (without exc_req): pc<=epc.
  - stall: pc holds.
- npcop decode (no exc/eret/stall); all arithmetic is modulo 2^WIDTH:
  - SEQ: pc+4.
  - BR: cmp_true ? pc_d+4+(sext(imm16)<<2) : pc+4.
  - J, JAL: {pc_d[WIDTH-1:28], imm26, 2'b00}.
  - JR, JALR, RET: reg_target.
  - Misaligned targets are loaded unchanged and only flagged through pc_misaligned.
- RAS updates happen only when the PC advances under npcop control. No push or pop occurs in a cycle with stall, exc_req or eret.
  - Push (JAL, JALR): write pc_d+8 at the top pointer and advance the pointer modulo RAS_DEPTH.
    - ras_count increments, saturating at RAS_DEPTH.
    - When the stack is full, the push overwrites the oldest entry (wrap-around).
  - Pop (RET):
    - If ras_count>0: compare the top entry with reg_target, retreat the pointer, decrement ras_count.
    - If ras_count==0: pointer and count unchanged; the pop counts as a miss.
- Miss reporting:
  - A miss is an empty RAS or top != reg_target.
  - ras_miss is asserted for exactly the next cycle after the miss.
  - ras_miss_cnt increments on each miss, saturating at all-ones.
  - ras_miss is 0 in every other cycle.
- The RET redirect target is always reg_target; the RAS never alters the PC.
- exc_req and eret leave RAS contents and counters untouched.
- Reset asserted mid-stall or mid-redirect wins on that edge.

Test Plan:
- Reset, then 3 SEQ cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; ras_count=0.
- BR with pc_d=0x3004, imm16=0xFFFF, cmp_true=1 -> pc=0x3004. Same with cmp_true=0, pc=0x3008 -> pc=0x300C.
- JAL with pc_d=0x3010, imm26=0x0000C10, then RET with reg_target=0x3018:
  - JAL -> pc=0x3040, RAS top 0x3018.
  - RET -> pc=0x3018, ras_miss stays 0, ras_count 1->0.
- 9 JALs with RAS_DEPTH=8, then 9 RETs with correct targets:
  - ras_count saturates at 8.
  - First 8 RETs hit; the 9th (empty) RET gives ras_miss=1 and ras_miss_cnt=1.
- stall=1 with npcop=JAL for 2 cycles -> pc held, ras_count unchanged. exc_req=1 together with stall -> pc=0x4180. Then eret with epc=0x3020 -> pc=0x3020.
- RET with reg_target=0x3002 against RAS top 0x3040 -> pc=0x3002, pc_misaligned=1, ras_miss pulse, ras_miss_cnt incremented.

Source files
------------

// File: rtl/npc_ras.sv
// npc_ras: F-stage PC register with next-PC selection, stall hold,
// exception/eret redirection and a circular return-address stack (RAS)
// that checks each RET against its prediction and counts mispredictions.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall               hold the PC (no RAS activity)
//   npcop               D-stage next-PC op (SEQ/BR/J/JAL/JR/JALR/RET, 7=SEQ)
//   cmp_true            branch condition resolved in D
//   pc_d                PC of the instruction in D
//   imm16, imm26        branch offset / jump index
//   reg_target          forwarded rs value for JR/JALR/RET
//   exc_req, eret, epc  exception redirect, return-from-exception and its target
//   pc                  registered F-stage PC
//   pc_plus4            pc+4 (combinational)
//   pc_misaligned       pc[1:0] != 0 (combinational)
//   ras_miss            one-cycle registered pulse after a RET misprediction
//   ras_miss_cnt        saturating count of RET mispredictions
//   ras_count           number of valid RAS entries
module npc_ras #(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       RAS_DEPTH  = 8,
  parameter logic [WIDTH-1:0]  RESET_PC   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0]  EXC_VECTOR = WIDTH'(32'h0000_4180),
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   npcop,
  input  logic                         cmp_true,
  input  logic [WIDTH-1:0]             pc_d,
  input  logic [15:0]                  imm16,
  input  logic [25:0]                  imm26,
  input  logic [WIDTH-1:0]             reg_target,
  input  logic                         exc_req,
  input  logic                         eret,
  input  logic [WIDTH-1:0]             epc,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic                         pc_misaligned,
  output logic                         ras_miss,
  output logic [CNT_W-1:0]             ras_miss_cnt,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned RCW   = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BR   = 3'd1,
    OP_J    = 3'd2,
    OP_JAL  = 3'd3,
    OP_JR   = 3'd4,
    OP_JALR = 3'd5,
    OP_RET  = 3'd6,
    OP_RSV  = 3'd7
  } npcop_e;

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [RCW-1:0]   ras_count_q, ras_count_d;
  logic             ras_miss_q, ras_miss_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  npcop_e           op;
  logic             advance;
  logic             push;
  logic             pop;
  logic             miss;
  logic [WIDTH-1:0] seq_target;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jmp_target;
  logic [WIDTH-1:0] ras_top;

  assign op         = npcop_e'(npcop);
  // RAS only moves when the PC advances under npcop control
  assign advance    = !exc_req && !eret && !stall;
  assign push       = advance && ((op == OP_JAL) || (op == OP_JALR));
  assign pop        = advance && (op == OP_RET);
  assign seq_target = fetch_pc_q + WIDTH'(4);
  assign br_target  = pc_d + WIDTH'(4) + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign jmp_target = {pc_d[WIDTH-1:28], imm26, 2'b00};
  // top of stack sits just below the write pointer
  assign ras_top    = ras_mem_q[ras_ptr_q - PTR_W'(1)];
  assign miss       = pop && ((ras_count_q == '0) || (ras_top != reg_target));

  // Next-PC selection: exc_req > eret > stall > npcop
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (exc_req) begin
      fetch_pc_d = EXC_VECTOR;
    end else if (eret) begin
      fetch_pc_d = epc;
    end else if (!stall) begin
      case (op)
        OP_BR:                   fetch_pc_d = cmp_true ? br_target : seq_target;
        OP_J, OP_JAL:            fetch_pc_d = jmp_target;
        OP_JR, OP_JALR, OP_RET:  fetch_pc_d = reg_target;
        default:                 fetch_pc_d = seq_target;
      endcase
    end
  end

  // RAS pointer/occupancy and miss bookkeeping
  always_comb begin
    ras_ptr_d   = ras_ptr_q;
    ras_count_d = ras_count_q;
    ras_miss_d  = miss;
    miss_cnt_d  = miss_cnt_q;
    if (push) begin
      ras_ptr_d = ras_ptr_q + PTR_W'(1);
      if (ras_count_q != RCW'(RAS_DEPTH)) begin
        ras_count_d = ras_count_q + RCW'(1);
      end
    end else if (pop && (ras_count_q != '0)) begin
      ras_ptr_d   = ras_ptr_q - PTR_W'(1);
      ras_count_d = ras_count_q - RCW'(1);
    end
    if (miss && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      ras_ptr_q   <= '0;
      ras_count_q <= '0;
      ras_miss_q  <= 1'b0;
      miss_cnt_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_count_q <= ras_count_d;
      ras_miss_q  <= ras_miss_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Entry storage needs no reset; a full-stack push overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      ras_mem_q[ras_ptr_q] <= pc_d + WIDTH'(8);
    end
  end

  assign pc            = fetch_pc_q;
  assign pc_plus4      = seq_target;
  assign pc_misaligned = (fetch_pc_q[1:0] != 2'b00);
  assign ras_miss      = ras_miss_q;
  assign ras_miss_cnt  = miss_cnt_q;
  assign ras_count     = ras_count_q;

endmodule

// File: tb/tb_npc_ras.sv
// Bench for npc_ras: stimulus pushes the expected post-edge state into a
// queue; an independent monitor pops and compares after every clock edge.
module tb_npc_ras;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  npcop = 3'd0;
  logic        cmp_true = 1'b0;
  logic [31:0] pc_d = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] reg_target = '0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_misaligned;
  logic        ras_miss;
  logic [15:0] ras_miss_cnt;
  logic [3:0]  ras_count;

  npc_ras dut (
    .clk(clk), .reset(reset), .stall(stall), .npcop(npcop), .cmp_true(cmp_true),
    .pc_d(pc_d), .imm16(imm16), .imm26(imm26), .reg_target(reg_target),
    .exc_req(exc_req), .eret(eret), .epc(epc), .pc(pc), .pc_plus4(pc_plus4),
    .pc_misaligned(pc_misaligned), .ras_miss(ras_miss), .ras_miss_cnt(ras_miss_cnt),
    .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          cnt;
    bit          miss;
    int          mcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // reference state: the RAS as a plain list of return addresses
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_ras[$];
  int          m_mcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // monitor: one expected snapshot per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("pc_plus4", pc_plus4, e.pc + 32'd4);
        check("pc_misaligned", 32'(pc_misaligned), 32'(e.pc[1:0] != 2'b00));
        check("ras_count", 32'(ras_count), 32'(e.cnt));
        check("ras_miss", 32'(ras_miss), 32'(e.miss));
        check("ras_miss_cnt", 32'(ras_miss_cnt), 32'(e.mcnt));
      end
    end
  end

  // drive one cycle of inputs at negedge and record what the next edge must produce
  task automatic step(input bit rst, input bit st, input bit ex, input bit er,
                      input logic [2:0] op, input bit cmp, input logic [31:0] pcd,
                      input logic [15:0] i16, input logic [25:0] i26,
                      input logic [31:0] rt, input logic [31:0] ep);
    exp_t e;
    bit   miss;
    @(negedge clk);
    reset = rst; stall = st; exc_req = ex; eret = er; npcop = op; cmp_true = cmp;
    pc_d = pcd; imm16 = i16; imm26 = i26; reg_target = rt; epc = ep;
    miss = 1'b0;
    if (rst) begin
      m_pc = RST_PC;
      m_ras.delete();
      m_mcnt = 0;
    end else if (ex) begin
      m_pc = EXC_PC;
    end else if (er) begin
      m_pc = ep;
    end else if (!st) begin
      case (op)
        3'd1: m_pc = cmp ? pcd + 32'd4 + 32'(int'($signed(i16)) * 4) : m_pc + 32'd4;
        3'd2: m_pc = (pcd & 32'hF000_0000) | (32'(i26) * 32'd4);
        3'd3: begin
          m_pc = (pcd & 32'hF000_0000) | (32'(i26) * 32'd4);
          m_ras.push_back(pcd + 32'd8);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        3'd4: m_pc = rt;
        3'd5: begin
          m_pc = rt;
          m_ras.push_back(pcd + 32'd8);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        3'd6: begin
          m_pc = rt;
          if (m_ras.size() == 0) miss = 1'b1;
          else begin
            if (m_ras[$] != rt) miss = 1'b1;
            void'(m_ras.pop_back());
          end
          if (miss && m_mcnt < 65535) m_mcnt++;
        end
        default: m_pc = m_pc + 32'd4;
      endcase
    end
    e.pc = m_pc; e.cnt = m_ras.size(); e.miss = miss; e.mcnt = m_mcnt;
    exp_q.push_back(e);
  endtask

  task automatic op_step(input logic [2:0] op, input logic [31:0] pcd,
                         input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rt);
    step(0, 0, 0, 0, op, 1'b0, pcd, i16, i26, rt, 32'd0);
  endtask

  initial begin
    logic [31:0] rt;
    logic [2:0]  op;
    // reset and sequential fetch
    step(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) op_step(3'd0, 0, 0, 0, 0);
    // taken branch backwards, then not-taken branch
    step(0, 0, 0, 0, 3'd1, 1, 32'h3004, 16'hFFFF, 0, 0, 0);
    op_step(3'd0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3'd1, 0, 32'h3008, 16'hFFFF, 0, 0, 0);
    // call/return pair that predicts correctly
    op_step(3'd3, 32'h3010, 0, 26'h0000C10, 0);
    op_step(3'd6, 0, 0, 0, 32'h3018);
    // overflow the stack, then unwind one past empty
    for (int i = 0; i < 9; i++) op_step(3'd3, 32'h3100 + 32'(i * 16), 0, 26'h0000C10, 0);
    for (int i = 8; i >= 1; i--) op_step(3'd6, 0, 0, 0, 32'h3108 + 32'(i * 16));
    op_step(3'd6, 0, 0, 0, 32'h3108);
    // stalled JAL must not push; exception beats stall; eret returns
    step(0, 1, 0, 0, 3'd3, 0, 32'h3038, 0, 26'h0000C10, 0, 0);
    step(0, 1, 0, 0, 3'd3, 0, 32'h3038, 0, 26'h0000C10, 0, 0);
    step(0, 1, 1, 0, 3'd3, 0, 32'h3038, 0, 26'h0000C10, 0, 0);
    step(0, 0, 0, 1, 3'd3, 0, 32'h3038, 0, 26'h0000C10, 0, 32'h3020);
    // mispredicted, misaligned return
    op_step(3'd3, 32'h3038, 0, 26'h0000C10, 0);
    op_step(3'd6, 0, 0, 0, 32'h3002);
    op_step(3'd0, 0, 0, 0, 0);
    op_step(3'd7, 0, 0, 0, 0);
    // randomized traffic including reset against stall/redirect
    for (int n = 0; n < 3000; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd6 && m_ras.size() > 0 && $urandom_range(0, 3) != 0) rt = m_ras[$];
      else rt = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           op, 1'($urandom), $urandom, 16'($urandom), 26'($urandom), rt, $urandom);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
